mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port data memory between the pipeline Memory stage and an external DMA/loader port. The DMA port streams image data in and results out.
- The CPU has priority. The DMA gets any cycle the Memory stage leaves idle.
- A starvation guard forces a bounded DMA burst. During that burst the pipeline is frozen through cpuStall, which feeds the hazards unit.

Parameters:
- DATA_WIDTH, 48, memory word width (one scalar or one packed 6x8 vector).
- ADDRESS_WIDTH, 48, memory address width.
- MAX_WAIT, 8, consecutive denied DMA cycles before a forced burst (>=1).
- BURST_MAX, 16, maximum granted DMA beats per forced burst (>=1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpuActive  in  1  Memory-stage instruction accesses memory this cycle.
- cpuWriteEnable  in  1  Memory-stage store.
- cpuAddress  in  ADDRESS_WIDTH  Memory-stage address (ALU result).
- cpuWriteData  in  DATA_WIDTH  store data.
- cpuReadData  out  DATA_WIDTH  load data, combinational from memReadData.
- cpuStall  out  1  freeze fetch, decode, execute and memory stages.
- dmaReq  in  1  DMA beat request; held with its fields until granted.
- dmaWrite  in  1  beat is a write.
- dmaAddress  in  ADDRESS_WIDTH  DMA address.
- dmaWriteData  in  DATA_WIDTH  DMA write data.
- dmaGnt  out  1  beat accepted this cycle.
- dmaReadData  out  DATA_WIDTH  registered read data.
- dmaReadValid  out  1  dmaReadData valid (one-cycle pulse).
- memWriteEnable  out  1  to memory writeEnable.
- memAddress  out  ADDRESS_WIDTH  drives memory read and write address.
- memWriteData  out  DATA_WIDTH  to memory inputData.
- memReadData  in  DATA_WIDTH  memory outputData (combinational read).

Behaviour:
- Memory model: read is combinational; write is committed on the clock edge.
- States: CPU_OWN (reset state) and DMA_OWN. Registers: state, waitCount, beatCount, dmaReadValid, dmaReadData.
- Reset (asynchronous): state=CPU_OWN; waitCount=0; beatCount=0; dmaReadValid=0; dmaReadData=0.
- While reset is high, dmaGnt, memWriteEnable and cpuStall are forced 0.

CPU_OWN:
- cpuStall=0.
- dmaGnt = dmaReq & !cpuActive.
- Memory mux selects the DMA when dmaGnt=1, otherwise the CPU.
- memWriteEnable = the selected requester's write, gated by cpuActive or dmaGnt.

waitCount:
- Increments when dmaReq & cpuActive.
- Clears when dmaGnt or !dmaReq.
- If dmaReq & cpuActive & waitCount==MAX_WAIT-1: next state=DMA_OWN, beatCount=0, waitCount=0.

DMA_OWN:
- cpuStall=1. The Memory-stage access is not performed (CPU write suppressed).
- dmaGnt=dmaReq, and the memory is routed to the DMA.
- beatCount increments on each grant.
- Exit to CPU_OWN when !dmaReq, or when a grant occurs with beatCount==BURST_MAX-1.
- The exit takes effect the next cycle; cpuStall deasserts that cycle.
- The stalled CPU access is serviced in its first CPU_OWN cycle.

Read return:
- A granted DMA read (dmaGnt & !dmaWrite) captures memReadData into dmaReadData at the edge.
- dmaReadValid=1 for exactly the following cycle (latency 1).
- Back-to-back reads give back-to-back valid pulses.
- A granted write produces no valid pulse.

Simultaneous events:
- cpuActive and dmaReq in CPU_OWN below threshold: the CPU wins.
- A CPU access during DMA_OWN is held by the stall and never lost.

Other rules:
- cpuReadData is meaningful only when cpuStall=0.
- No address checking is performed; addresses pass through unchanged.
- Reset mid-burst aborts the burst; an in-flight dmaReadValid is cleared.

Decomposition:
- Shared package: arb_state_t enum {CPU_OWN, DMA_OWN}.
- The same package holds the MAX_WAIT and BURST_MAX defaults, used by CPU top-level instantiation.
- One sub-module: sat_counter (parameterised width, increment/clear, terminal-count flag). It is instantiated twice, for waitCount and beatCount.

Test Plan:
- Idle CPU, DMA write 0x0000_0000_00AB to addr 5, then read addr 5 -> dmaGnt same cycle each; dmaReadValid the cycle after the read with dmaReadData=0xAB; cpuStall stays 0.
- cpuActive=1 continuously, dmaReq=1, MAX_WAIT=8 -> dmaGnt=0 for 8 cycles; DMA_OWN on cycle 9; cpuStall=1; DMA granted.
- Forced burst with dmaReq held, BURST_MAX=16 -> exactly 16 grants; cpuStall drops the next cycle; CPU store to addr 3 then commits, and a memory readback of addr 3 shows the CPU data.
- DMA drops dmaReq after 4 beats in DMA_OWN -> return to CPU_OWN the next cycle; beatCount and waitCount are 0.
- Simultaneous CPU store (addr 7, 0x11) and DMA write (addr 7, 0x22) below threshold -> memory holds 0x11; DMA granted once cpuActive=0, then holds 0x22.
- Reset asserted mid-burst after a granted read -> immediately cpuStall=0, dmaGnt=0, dmaReadValid=0, state CPU_OWN; normal arbitration resumes after release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package mem_port_arbiter_pkg;

  // Who owns the memory port this cycle.
  typedef enum logic {
    CPU_OWN = 1'b0,
    DMA_OWN = 1'b1
  } arb_state_t;

  // Defaults used when the CPU top level instantiates the arbiter.
  localparam int DATA_WIDTH_DEFAULT    = 48;
  localparam int ADDRESS_WIDTH_DEFAULT = 48;
  localparam int MAX_WAIT_DEFAULT      = 8;
  localparam int BURST_MAX_DEFAULT     = 16;

  // Bits needed to count 0..max_count-1 (never less than one bit).
  function automatic int count_width(input int max_count);
    int w;
    w = $clog2(max_count);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU, DMA and memory-side signals around the arbiter.
//
// DMA handshake: dmaReq is a request that, once raised, is held together with
// dmaWrite/dmaAddress/dmaWriteData until a cycle in which dmaGnt is high; that
// cycle is the beat. A granted read returns data one cycle later as a
// single-cycle dmaReadValid pulse with dmaReadData. There is no back-pressure
// on the read return. The CPU side has no handshake: cpuStall freezes the
// Memory stage, which keeps presenting the same access until cpuStall drops.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH    = 48,
  parameter int ADDRESS_WIDTH = 48
);
  // Memory-stage side
  logic                     cpuActive;
  logic                     cpuWriteEnable;
  logic [ADDRESS_WIDTH-1:0] cpuAddress;
  logic [DATA_WIDTH-1:0]    cpuWriteData;
  logic [DATA_WIDTH-1:0]    cpuReadData;
  logic                     cpuStall;
  // DMA / loader side
  logic                     dmaReq;
  logic                     dmaWrite;
  logic [ADDRESS_WIDTH-1:0] dmaAddress;
  logic [DATA_WIDTH-1:0]    dmaWriteData;
  logic                     dmaGnt;
  logic [DATA_WIDTH-1:0]    dmaReadData;
  logic                     dmaReadValid;
  // Memory side
  logic                     memWriteEnable;
  logic [ADDRESS_WIDTH-1:0] memAddress;
  logic [DATA_WIDTH-1:0]    memWriteData;
  logic [DATA_WIDTH-1:0]    memReadData;

  // Arbiter view
  modport slave (
    input  cpuActive, cpuWriteEnable, cpuAddress, cpuWriteData,
    output cpuReadData, cpuStall,
    input  dmaReq, dmaWrite, dmaAddress, dmaWriteData,
    output dmaGnt, dmaReadData, dmaReadValid,
    output memWriteEnable, memAddress, memWriteData,
    input  memReadData
  );

  // Surrounding system view (pipeline, DMA engine, memory)
  modport master (
    output cpuActive, cpuWriteEnable, cpuAddress, cpuWriteData,
    input  cpuReadData, cpuStall,
    output dmaReq, dmaWrite, dmaAddress, dmaWriteData,
    input  dmaGnt, dmaReadData, dmaReadValid,
    input  memWriteEnable, memAddress, memWriteData,
    output memReadData
  );
endinterface

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear and terminal-count flag.
module sat_counter #(
  parameter int          WIDTH    = 4,
  parameter int unsigned TERMINAL = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);
  localparam logic [WIDTH-1:0] TC_VALUE = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] count_q, count_d;

  assign tc_o    = (count_q == TC_VALUE);
  assign count_o = count_q;

  // Clear wins over increment; the count holds once it reaches TERMINAL.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !tc_o) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port data memory between the pipeline Memory stage and a
// DMA/loader port. CPU has priority; a starvation guard hands the DMA a
// bounded burst while the pipeline is frozen through cpuStall.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT,
  parameter int MAX_WAIT      = MAX_WAIT_DEFAULT,
  parameter int BURST_MAX     = BURST_MAX_DEFAULT,
  localparam int WAIT_W       = count_width(MAX_WAIT),
  localparam int BEAT_W       = count_width(BURST_MAX)
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output arb_state_t        state_o,
  output logic [WAIT_W-1:0] wait_count_o,
  output logic [BEAT_W-1:0] beat_count_o
);
  arb_state_t state_q, state_d;

  logic                  dma_read_valid_q, dma_read_valid_d;
  logic [DATA_WIDTH-1:0] dma_read_data_q, dma_read_data_d;

  logic gnt_raw;
  logic stall_raw;
  logic sel_dma;
  logic contended;
  logic wait_hit;
  logic burst_exit;
  logic wait_inc, wait_clr, wait_tc;
  logic beat_inc, beat_clr, beat_tc;

  // DMA wants the port while the CPU is using it.
  assign contended = bus.dmaReq && bus.cpuActive;
  // The contended cycle that exhausts the DMA's patience.
  assign wait_hit  = (state_q == CPU_OWN) && contended && wait_tc;
  // Burst ends when the DMA goes quiet or its last allowed beat is granted.
  assign burst_exit = (state_q == DMA_OWN) &&
                      (!bus.dmaReq || (gnt_raw && beat_tc));

  assign wait_inc = contended;
  assign wait_clr = (state_q == DMA_OWN) || !contended || wait_hit;
  assign beat_inc = (state_q == DMA_OWN) && gnt_raw;
  assign beat_clr = (state_q == CPU_OWN) || burst_exit;

  sat_counter #(
    .WIDTH    (WAIT_W),
    .TERMINAL (MAX_WAIT - 1)
  ) u_wait_count (
    .clk_i   (clock),
    .rst_i   (reset),
    .inc_i   (wait_inc),
    .clr_i   (wait_clr),
    .count_o (wait_count_o),
    .tc_o    (wait_tc)
  );

  sat_counter #(
    .WIDTH    (BEAT_W),
    .TERMINAL (BURST_MAX - 1)
  ) u_beat_count (
    .clk_i   (clock),
    .rst_i   (reset),
    .inc_i   (beat_inc),
    .clr_i   (beat_clr),
    .count_o (beat_count_o),
    .tc_o    (beat_tc)
  );

  // Ownership state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= CPU_OWN;
    end else begin
      state_q <= state_d;
    end
  end

  // Ownership transitions: starvation enters a burst, burst end returns.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CPU_OWN: if (wait_hit)   state_d = DMA_OWN;
      DMA_OWN: if (burst_exit) state_d = CPU_OWN;
      default: state_d = CPU_OWN;
    endcase
  end

  // Grant, stall and port routing decoded from the current owner.
  always_comb begin
    gnt_raw   = 1'b0;
    stall_raw = 1'b0;
    sel_dma   = 1'b0;
    case (state_q)
      CPU_OWN: begin
        gnt_raw = bus.dmaReq && !bus.cpuActive;
        sel_dma = gnt_raw;
      end
      DMA_OWN: begin
        gnt_raw   = bus.dmaReq;
        stall_raw = 1'b1;
        sel_dma   = 1'b1;
      end
      default: begin
        gnt_raw   = 1'b0;
        stall_raw = 1'b0;
        sel_dma   = 1'b0;
      end
    endcase
  end

  // Reset forces the handshake and write strobes low even mid-cycle.
  assign bus.dmaGnt         = gnt_raw && !reset;
  assign bus.cpuStall       = stall_raw && !reset;
  assign bus.memWriteEnable = !reset &&
                              (sel_dma ? (gnt_raw && bus.dmaWrite)
                                       : (bus.cpuActive && bus.cpuWriteEnable));
  assign bus.memAddress     = sel_dma ? bus.dmaAddress : bus.cpuAddress;
  assign bus.memWriteData   = sel_dma ? bus.dmaWriteData : bus.cpuWriteData;
  assign bus.cpuReadData    = bus.memReadData;

  assign bus.dmaReadValid = dma_read_valid_q;
  assign bus.dmaReadData  = dma_read_data_q;
  assign state_o          = state_q;

  // A granted read latches the memory word; the data holds until the next one.
  always_comb begin
    dma_read_valid_d = gnt_raw && !bus.dmaWrite;
    dma_read_data_d  = dma_read_data_q;
    if (dma_read_valid_d) begin
      dma_read_data_d = bus.memReadData;
    end
  end

  // Read-return registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dma_read_valid_q <= 1'b0;
      dma_read_data_q  <= '0;
    end else begin
      dma_read_valid_q <= dma_read_valid_d;
      dma_read_data_q  <= dma_read_data_d;
    end
  end
endmodule
